banco_de_registradores_p: RTL and testbench

BANCO_DE_REGISTRADORES_P -- requirements
Module: banco_de_registradores_p

---
 rtl/banco_de_registradores_p.sv | 135 +++++++++++++
 tb/tb_banco_de_registradores_p.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/banco_de_registradores_p.sv
// Register file with pending-writeback scoreboard, same-cycle write bypass
// and a sequential whole-file clear engine.
module banco_de_registradores_p #(
    parameter int DATA_W   = 32,
    parameter int NREG     = 32,
    parameter int ADDR_W   = 6,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              Write_UC,
    input  logic [ADDR_W-1:0] S,
    input  logic [DATA_W-1:0] W_Data,
    input  logic [ADDR_W-1:0] OP1,
    input  logic [ADDR_W-1:0] OP2,
    output logic [DATA_W-1:0] L1,
    output logic [DATA_W-1:0] L2,
    input  logic              Set_Pend,
    input  logic [ADDR_W-1:0] Pend_Addr,
    output logic              Pend1,
    output logic              Pend2,
    input  logic              Clr_Start,
    output logic              Busy,
    output logic              Clr_Done,
    output logic              Wr_Drop
);

    localparam logic [ADDR_W:0]   NREG_W = (ADDR_W+1)'(NREG);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(NREG - 1);
    localparam bit                ZR     = (ZERO_REG != 0);
    localparam bit                BP     = (BYPASS != 0);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx;
    logic              last;
    logic              wr_acc, set_acc, fwd;
    logic [DATA_W-1:0] mem [NREG];
    logic [NREG-1:0]   pend;
    logic [DATA_W-1:0] rd1, rd2;
    logic              pnd1, pnd2, ok1, ok2;

    assign last    = (idx == LAST);
    assign wr_acc  = Write_UC && !Busy && ({1'b0, S} < NREG_W) && !(ZR && S == '0);
    assign set_acc = Set_Pend && !Busy;
    // Forwarding is suppressed while reset is held so every output reads zero.
    assign fwd     = BP && wr_acc && reset_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) idx <= '0;
            else                 idx <= idx + ADDR_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Clr_Start) state_d = CLEAR;
            CLEAR:   if (last)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state_q == CLEAR);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            Clr_Done <= 1'b0;
            Wr_Drop  <= 1'b0;
        end else begin
            Clr_Done <= Busy && last;
            Wr_Drop  <= Busy && Write_UC;
        end
    end

    // A same-cycle Set_Pend is assigned after the write's clear, so set wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
            pend <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (Busy && idx == ADDR_W'(i)) begin
                    mem[i]  <= '0;
                    pend[i] <= 1'b0;
                end else begin
                    if (wr_acc && S == ADDR_W'(i)) begin
                        mem[i]  <= W_Data;
                        pend[i] <= 1'b0;
                    end
                    if (set_acc && Pend_Addr == ADDR_W'(i)) pend[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd1  = '0;
        rd2  = '0;
        pnd1 = 1'b0;
        pnd2 = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (OP1 == ADDR_W'(i)) begin
                rd1  = mem[i];
                pnd1 = pend[i];
            end
            if (OP2 == ADDR_W'(i)) begin
                rd2  = mem[i];
                pnd2 = pend[i];
            end
        end
    end

    assign ok1 = ({1'b0, OP1} < NREG_W) && !(ZR && OP1 == '0);
    assign ok2 = ({1'b0, OP2} < NREG_W) && !(ZR && OP2 == '0);

    always_comb begin
        L1    = '0;
        L2    = '0;
        Pend1 = ok1 && pnd1;
        Pend2 = ok2 && pnd2;
        if (ok1) L1 = (fwd && S == OP1) ? W_Data : rd1;
        if (ok2) L2 = (fwd && S == OP2) ? W_Data : rd2;
    end

endmodule

// File: tb/tb_banco_de_registradores_p.sv
// Directed bench: a bypassing and a non-bypassing register file share stimulus
// and are checked every cycle against an array-based reference model.
module tb_banco_de_registradores_p;

    logic        clock;
    logic        reset_n;
    logic        we, sp, cs;
    logic [5:0]  s, op1, op2, pa;
    logic [31:0] wd;
    logic [31:0] l1a, l2a, l1b, l2b;
    logic        p1a, p2a, p1b, p2b;
    logic        busy_a, done_a, drop_a, busy_b, done_b, drop_b;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [31:0] mm [32];
    bit          mp [32];
    int          left;
    bit          mdone, mdrop;

    banco_de_registradores_p #(.DATA_W(32), .NREG(32), .ADDR_W(6), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clock(clock), .reset_n(reset_n), .Write_UC(we), .S(s), .W_Data(wd),
        .OP1(op1), .OP2(op2), .L1(l1a), .L2(l2a), .Set_Pend(sp), .Pend_Addr(pa),
        .Pend1(p1a), .Pend2(p2a), .Clr_Start(cs), .Busy(busy_a), .Clr_Done(done_a), .Wr_Drop(drop_a));

    banco_de_registradores_p #(.DATA_W(32), .NREG(32), .ADDR_W(6), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clock(clock), .reset_n(reset_n), .Write_UC(we), .S(s), .W_Data(wd),
        .OP1(op1), .OP2(op2), .L1(l1b), .L2(l2b), .Set_Pend(sp), .Pend_Addr(pa),
        .Pend1(p1b), .Pend2(p2b), .Clr_Start(cs), .Busy(busy_b), .Clr_Done(done_b), .Wr_Drop(drop_b));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit macc();
        return reset_n && we && (left == 0) && s < 32 && s != 0;
    endfunction

    function automatic logic [31:0] mrd(input logic [5:0] a, input bit byp);
        if (a >= 32 || a == 0) return 32'h0;
        if (byp && macc() && s == a) return wd;
        return mm[a];
    endfunction

    function automatic bit mpend(input logic [5:0] a);
        if (a >= 32 || a == 0) return 1'b0;
        return mp[a];
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                mm[i] <= 32'h0;
                mp[i] <= 1'b0;
            end
            left  <= 0;
            mdone <= 1'b0;
            mdrop <= 1'b0;
        end else begin
            mdrop <= (left > 0) && we;
            if (left > 0) begin
                mm[32 - left] <= 32'h0;
                mp[32 - left] <= 1'b0;
                left  <= left - 1;
                mdone <= (left == 1);
            end else begin
                mdone <= 1'b0;
                if (macc()) begin
                    mm[s] <= wd;
                    mp[s] <= 1'b0;
                end
                if (sp && pa < 32) mp[pa] <= 1'b1;
                if (cs) left <= 32;
            end
        end
    end

    always @(negedge clock) begin
        chk("L1", l1a, mrd(op1, 1'b1));
        chk("L2", l2a, mrd(op2, 1'b1));
        chk("L1_nobypass", l1b, mrd(op1, 1'b0));
        chk("L2_nobypass", l2b, mrd(op2, 1'b0));
        chk("Pend1", {31'h0, p1a}, {31'h0, mpend(op1)});
        chk("Pend2", {31'h0, p2a}, {31'h0, mpend(op2)});
        chk("Busy", {31'h0, busy_a}, {31'h0, left > 0});
        chk("Clr_Done", {31'h0, done_a}, {31'h0, mdone});
        chk("Wr_Drop", {31'h0, drop_a}, {31'h0, mdrop});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        we = 0; sp = 0; cs = 0;
        s = 0; op1 = 0; op2 = 0; pa = 0; wd = 0;
        #2;
        chk("reset_busy", {31'h0, busy_a}, 32'h0);
        chk("reset_L1", l1a, 32'h0);
        #10 reset_n = 1'b1;
        tick();

        // same-cycle bypass vs. registered read
        we = 1; s = 5; wd = 32'hDEADBEEF; op1 = 5;
        #1;
        chk("bypass_L1", l1a, 32'hDEADBEEF);
        chk("nobypass_L1_same", l1b, 32'h0);
        tick();
        we = 0;
        #1;
        chk("nobypass_L1_next", l1b, 32'hDEADBEEF);

        // zero register and out-of-range reads
        we = 1; s = 0; wd = 32'h1234; op2 = 0; op1 = 40;
        #1;
        chk("zero_L2_bypass", l2a, 32'h0);
        chk("oor_L1", l1a, 32'h0);
        chk("oor_Pend1", {31'h0, p1a}, 32'h0);
        tick();
        we = 0;
        #1;
        chk("zero_L2_after", l2a, 32'h0);

        // pending set, then cleared by writeback
        op1 = 7; sp = 1; pa = 7;
        #1;
        chk("pend7_before", {31'h0, p1a}, 32'h0);
        tick();
        sp = 0;
        #1;
        chk("pend7_set", {31'h0, p1a}, 32'h1);
        we = 1; s = 7; wd = 32'h77;
        #1;
        chk("pend7_hold", {31'h0, p1a}, 32'h1);
        tick();
        we = 0;
        #1;
        chk("pend7_cleared", {31'h0, p1a}, 32'h0);
        chk("reg7", l1a, 32'h77);

        // set wins over same-cycle writeback
        op2 = 9; sp = 1; pa = 9; we = 1; s = 9; wd = 32'h99;
        tick();
        sp = 0; we = 0;
        #1;
        chk("pend9_setwins", {31'h0, p2a}, 32'h1);
        chk("reg9", l2a, 32'h99);

        // fill 1..31 with nonzero data
        for (int i = 1; i < 32; i++) begin
            we = 1; s = 6'(i); wd = 32'h01010101 * i + 32'h10;
            tick();
        end
        we = 0;
        op1 = 31;
        #1;
        chk("reg31_filled", l1a, 32'h01010101 * 31 + 32'h10);

        // sequential clear, with ignored restart, ignored Set_Pend and a dropped write
        cs = 1;
        tick();
        cs = 0;
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            n++;
            cs = (n == 5);
            sp = (n == 5); pa = 2;
            we = (n == 10); s = 3; wd = 32'hAAAA5555;
            if (n == 11) chk("wr_drop_pulse", {31'h0, drop_a}, 32'h1);
            tick();
        end
        cs = 0; sp = 0; we = 0;
        chk("busy_cycles", n, 32);
        chk("clr_done_pulse", {31'h0, done_a}, 32'h1);
        tick();
        chk("clr_done_single", {31'h0, done_a}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            op1 = 6'(i); op2 = 6'(31 - i);
            #1;
            chk("cleared_L1", l1a, 32'h0);
            chk("cleared_Pend1", {31'h0, p1a}, 32'h0);
            tick();
        end

        // write and clear start in the same idle cycle: write lands first
        we = 1; s = 31; wd = 32'h5555; cs = 1; sp = 1; pa = 20;
        op1 = 31; op2 = 20;
        tick();
        we = 0; cs = 0; sp = 0;
        #1;
        chk("write_before_clear", l1a, 32'h5555);
        chk("pend20_set", {31'h0, p2a}, 32'h1);
        repeat (9) tick();

        // asynchronous reset mid-clear
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", {31'h0, busy_a}, 32'h0);
        chk("rst_L1", l1a, 32'h0);
        chk("rst_Pend2", {31'h0, p2a}, 32'h0);
        chk("rst_done", {31'h0, done_a}, 32'h0);
        chk("rst_drop", {31'h0, drop_a}, 32'h0);
        tick();
        tick();
        #2 reset_n = 1'b1;
        we = 1; s = 12; wd = 32'hCAFE; op1 = 12;
        tick();
        we = 0;
        #1;
        chk("post_reset_write", l1a, 32'hCAFE);
        chk("post_reset_no_done", {31'h0, done_a}, 32'h0);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
